// File: rtl/vx_ahb_line_bridge_if.sv
// vx_ahb_line_bridge_if: Vortex line-port and AHB-Lite manager signal bundle for the line bridge
// Vortex side: mem_req_* (valid/rw/byteen/addr/data/tag/ready), mem_rsp_* (valid/data/tag/ready)
// AHB side: HSEL/HWRITE/HTRANS/HBURST/HSIZE/HADDR/HWDATA/HWSTRB out of the bridge, HREADY/HRESP/HRDATA in
// master = the bridge's view, slave = the view of the core/memory environment around it
interface vx_ahb_line_bridge_if #(
    parameter int DATA_W  = 512,
    parameter int HDATA_W = 32,
    parameter int ADDR_W  = 26,
    parameter int TAG_W   = 8,
    parameter int HADDR_W = 32
) ();
    logic                 mem_req_valid;
    logic                 mem_req_rw;
    logic [DATA_W/8-1:0]  mem_req_byteen;
    logic [ADDR_W-1:0]    mem_req_addr;
    logic [DATA_W-1:0]    mem_req_data;
    logic [TAG_W-1:0]     mem_req_tag;
    logic                 mem_req_ready;
    logic                 mem_rsp_valid;
    logic [DATA_W-1:0]    mem_rsp_data;
    logic [TAG_W-1:0]     mem_rsp_tag;
    logic                 mem_rsp_ready;
    logic                 HSEL;
    logic                 HWRITE;
    logic [1:0]           HTRANS;
    logic [2:0]           HBURST;
    logic [2:0]           HSIZE;
    logic [HADDR_W-1:0]   HADDR;
    logic [HDATA_W-1:0]   HWDATA;
    logic [HDATA_W/8-1:0] HWSTRB;
    logic                 HREADY;
    logic                 HRESP;
    logic [HDATA_W-1:0]   HRDATA;

    modport master (
        input  mem_req_valid, mem_req_rw, mem_req_byteen, mem_req_addr, mem_req_data, mem_req_tag,
        output mem_req_ready,
        output mem_rsp_valid, mem_rsp_data, mem_rsp_tag,
        input  mem_rsp_ready,
        output HSEL, HWRITE, HTRANS, HBURST, HSIZE, HADDR, HWDATA, HWSTRB,
        input  HREADY, HRESP, HRDATA
    );

    modport slave (
        output mem_req_valid, mem_req_rw, mem_req_byteen, mem_req_addr, mem_req_data, mem_req_tag,
        input  mem_req_ready,
        input  mem_rsp_valid, mem_rsp_data, mem_rsp_tag,
        output mem_rsp_ready,
        input  HSEL, HWRITE, HTRANS, HBURST, HSIZE, HADDR, HWDATA, HWSTRB,
        output HREADY, HRESP, HRDATA
    );
endinterface

// File: rtl/vx_ahb_line_bridge.sv
// vx_ahb_line_bridge: turns one Vortex line request into a pipelined AHB-Lite INCR burst and reassembles reads
// clk, reset : clock and asynchronous active-high reset
// bus        : Vortex request/response handshakes and AHB-Lite manager signals (master modport)
// busy       : bridge not idle
// bus_err    : one-cycle pulse per errored beat
// err_count  : saturating count of errored beats
module vx_ahb_line_bridge #(
    parameter int                 DATA_W    = 512,
    parameter int                 HDATA_W   = 32,
    parameter int                 ADDR_W    = 26,
    parameter int                 TAG_W     = 8,
    parameter int                 HADDR_W   = 32,
    parameter logic [HADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic                clk,
    input  logic                reset,
    vx_ahb_line_bridge_if.master bus,
    output logic                busy,
    output logic                bus_err,
    output logic [7:0]          err_count
);
    localparam int BEATS = DATA_W / HDATA_W;
    localparam int SB    = HDATA_W / 8;
    localparam int CW    = BEATS > 1 ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0]      LAST       = CW'(BEATS - 1);
    localparam logic [HADDR_W-1:0] LINE_BYTES = HADDR_W'(DATA_W / 8);
    localparam logic [HADDR_W-1:0] BEAT_BYTES = HADDR_W'(SB);

    typedef enum logic [1:0] {IDLE, BURST, DRAIN, RSP} state_t;

    state_t              state, state_n;
    logic                rw_q, dvalid, nonseq;
    logic [DATA_W/8-1:0] byteen_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   line_q;
    logic [TAG_W-1:0]    tag_q;
    logic [CW-1:0]       acnt, dcnt;
    logic                accept, err_wait, beat_done, addr_acc;

    assign accept    = (state == IDLE) && bus.mem_req_valid;
    // first cycle of a two-cycle ERROR response: the pending address phase is withdrawn
    assign err_wait  = dvalid && bus.HRESP && !bus.HREADY;
    assign beat_done = dvalid && bus.HREADY;
    // err_wait implies HREADY=0, so no address is ever taken while it is being withdrawn
    assign addr_acc  = (state == BURST) && bus.HREADY;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n           = state;
        bus.mem_req_ready = state == IDLE;
        bus.mem_rsp_valid = state == RSP;
        bus.mem_rsp_data  = line_q;
        bus.mem_rsp_tag   = tag_q;
        bus.HTRANS        = (state == BURST && !err_wait) ? (nonseq ? 2'b10 : 2'b11) : 2'b00;
        bus.HSEL          = bus.HTRANS != 2'b00;
        bus.HWRITE        = (state == BURST) && rw_q;
        bus.HBURST        = 3'b001;
        bus.HSIZE         = 3'($clog2(SB));
        bus.HADDR         = state == BURST
                            ? BASE_ADDR + HADDR_W'(addr_q) * LINE_BYTES + HADDR_W'(acnt) * BEAT_BYTES
                            : '0;
        bus.HWDATA        = (dvalid && rw_q) ? line_q[int'(dcnt)*HDATA_W +: HDATA_W] : '0;
        bus.HWSTRB        = (dvalid && rw_q) ? byteen_q[int'(dcnt)*SB +: SB] : '0;
        busy              = state != IDLE;
        case (state)
            IDLE:    if (accept) state_n = BURST;
            BURST:   if (addr_acc && acnt == LAST) state_n = DRAIN;
            DRAIN:   if (bus.HREADY) state_n = rw_q ? IDLE : RSP;
            RSP:     if (bus.mem_rsp_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rw_q      <= 1'b0;
            byteen_q  <= '0;
            addr_q    <= '0;
            line_q    <= '0;
            tag_q     <= '0;
            acnt      <= '0;
            dcnt      <= '0;
            dvalid    <= 1'b0;
            nonseq    <= 1'b0;
            bus_err   <= 1'b0;
            err_count <= '0;
        end else begin
            if (accept) begin
                rw_q     <= bus.mem_req_rw;
                byteen_q <= bus.mem_req_byteen;
                addr_q   <= bus.mem_req_addr;
                line_q   <= bus.mem_req_data;
                tag_q    <= bus.mem_req_tag;
                acnt     <= '0;
                dcnt     <= '0;
                dvalid   <= 1'b0;
                nonseq   <= 1'b1;
            end else begin
                // after a withdrawn address the burst restarts with NONSEQ at the same beat
                if (err_wait)      nonseq <= 1'b1;
                else if (addr_acc) nonseq <= 1'b0;
                if (addr_acc) begin
                    acnt <= acnt + 1'b1;
                    dcnt <= acnt;
                end
                if (bus.HREADY) dvalid <= addr_acc;
                if (beat_done && !rw_q)
                    line_q[int'(dcnt)*HDATA_W +: HDATA_W] <= bus.HRESP ? '0 : bus.HRDATA;
            end
            bus_err <= beat_done && bus.HRESP;
            if (beat_done && bus.HRESP && err_count != 8'hFF) err_count <= err_count + 8'd1;
        end
    end
endmodule

// File: tb/tb_vx_ahb_line_bridge.sv
// tb_vx_ahb_line_bridge: vector table, random traffic against a line-level memory model, reset and wrap sequences
module tb_vx_ahb_line_bridge;
    localparam int DW = 512, HW = 32, AW = 26, TW = 8, HAW = 32;
    localparam int BEATS = DW / HW, BE = DW / 8;

    logic clk = 1'b0, reset;
    always #5 clk = ~clk;

    vx_ahb_line_bridge_if #(.DATA_W(DW), .HDATA_W(HW), .ADDR_W(AW), .TAG_W(TW), .HADDR_W(HAW)) b();
    vx_ahb_line_bridge_if #(.DATA_W(DW), .HDATA_W(HW), .ADDR_W(AW), .TAG_W(TW), .HADDR_W(HAW)) w();
    logic busy, bus_err, w_busy, w_bus_err;
    logic [7:0] err_count, w_err_count;

    vx_ahb_line_bridge #(.DATA_W(DW), .HDATA_W(HW), .ADDR_W(AW), .TAG_W(TW), .HADDR_W(HAW)) dut (
        .clk(clk), .reset(reset), .bus(b), .busy(busy), .bus_err(bus_err), .err_count(err_count));
    vx_ahb_line_bridge #(.DATA_W(DW), .HDATA_W(HW), .ADDR_W(AW), .TAG_W(TW), .HADDR_W(HAW),
                         .BASE_ADDR(32'hFFFF_FFC0)) dut_w (
        .clk(clk), .reset(reset), .bus(w), .busy(w_busy), .bus_err(w_bus_err), .err_count(w_err_count));

    int total = 0, bad = 0;
    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // slave memory (written from the bus) and reference memory (written from requests)
    logic [31:0] smem [int unsigned];
    logic [31:0] rmem [int unsigned];
    function automatic logic [31:0] init_word(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction
    function automatic logic [31:0] srd(input logic [31:0] a);
        return smem.exists(a) ? smem[a] : init_word(a);
    endfunction
    function automatic logic [31:0] rrd(input logic [31:0] a);
        return rmem.exists(a) ? rmem[a] : init_word(a);
    endfunction

    bit          dp_v, dp_w, p_ok, p_hready, p_hresp, accepted, done;
    logic [31:0] dp_a, line_base, p_addr, p_wdata;
    logic [1:0]  p_trans;
    logic [3:0]  p_strb;
    int          dp_wait, stall_beat, stall_n, err_beat, stall_pct, rsp_delay;
    int          cyc, t_acc, t_done, rsp_cnt, err_pulses, hold_bad, proto_bad, stab_bad, exp_errs;
    logic [31:0] a_log[$];
    logic [1:0]  t_log[$];
    logic [3:0]  s_log[$];
    logic [DW-1:0] rsp_data;
    logic [TW-1:0] rsp_tag;

    // one clock: observe at negedge, then drive the next cycle's inputs 1ns after posedge
    task automatic cycle();
        logic [31:0] wd;
        int beat;
        @(negedge clk);
        if (p_ok && !p_hready && !p_hresp &&
            {b.HADDR, b.HTRANS, b.HWDATA, b.HWSTRB} !== {p_addr, p_trans, p_wdata, p_strb}) stab_bad++;
        p_ok = 1; p_hready = b.HREADY; p_hresp = b.HRESP;
        p_addr = b.HADDR; p_trans = b.HTRANS; p_wdata = b.HWDATA; p_strb = b.HWSTRB;
        if (b.HSEL !== (b.HTRANS != 2'b00)) proto_bad++;
        if (dp_v && b.HRESP && !b.HREADY && b.HTRANS !== 2'b00) proto_bad++;
        if (dp_v && b.HREADY) begin
            if (dp_w) begin
                s_log.push_back(b.HWSTRB);
                if (!b.HRESP) begin
                    wd = srd(dp_a);
                    for (int k = 0; k < 4; k++) if (b.HWSTRB[k]) wd[k*8 +: 8] = b.HWDATA[k*8 +: 8];
                    smem[dp_a] = wd;
                end
            end
            dp_v = 0;
        end else if (dp_v) dp_wait++;
        if (b.HTRANS != 2'b00 && b.HREADY) begin
            a_log.push_back(b.HADDR); t_log.push_back(b.HTRANS);
            dp_v = 1; dp_a = b.HADDR; dp_w = b.HWRITE; dp_wait = 0;
        end
        if (bus_err) err_pulses++;
        if (!accepted && b.mem_req_valid && b.mem_req_ready) begin
            accepted = 1; t_acc = cyc;
        end else if (accepted && !done) begin
            if (b.mem_rsp_valid) begin
                if (rsp_cnt == 0) t_done = cyc;
                else if ({b.mem_rsp_data, b.mem_rsp_tag} !== {rsp_data, rsp_tag}) hold_bad++;
                if (b.mem_req_ready) hold_bad++;
                rsp_data = b.mem_rsp_data; rsp_tag = b.mem_rsp_tag; rsp_cnt++;
                if (b.mem_rsp_ready) done = 1;
            end else if (b.mem_req_ready) begin
                t_done = cyc; done = 1;
            end
        end
        @(posedge clk); #1;
        cyc++;
        if (accepted) b.mem_req_valid = 1'b0;
        b.mem_rsp_ready = b.mem_rsp_valid && rsp_cnt >= rsp_delay;
        if (dp_v) begin
            beat = int'((dp_a - line_base) >> 2);
            b.HRDATA = srd(dp_a);
            if (beat == err_beat) begin
                b.HREADY = dp_wait >= 1; b.HRESP = 1'b1;
            end else if (beat == stall_beat && dp_wait < stall_n) begin
                b.HREADY = 1'b0; b.HRESP = 1'b0;
            end else begin
                b.HREADY = $urandom_range(99) >= stall_pct; b.HRESP = 1'b0;
            end
        end else begin
            b.HREADY = 1'b1; b.HRESP = 1'b0; b.HRDATA = '0;
        end
    endtask

    task automatic start_txn(input bit rw, input logic [AW-1:0] addr, input logic [TW-1:0] tag,
                             input logic [DW-1:0] data, input logic [BE-1:0] be,
                             input int sb, input int sn, input int eb, input int rd);
        a_log.delete(); t_log.delete(); s_log.delete();
        line_base = 32'(addr) * 32'd64;
        stall_beat = sb; stall_n = sn; err_beat = eb; rsp_delay = rd;
        accepted = 0; done = 0; rsp_cnt = 0; err_pulses = 0; hold_bad = 0; proto_bad = 0; stab_bad = 0;
        rsp_data = '0; rsp_tag = '0;
        b.mem_req_rw = rw; b.mem_req_addr = addr; b.mem_req_tag = tag;
        b.mem_req_data = data; b.mem_req_byteen = be; b.mem_req_valid = 1'b1;
    endtask

    task automatic run_txn(input bit rw, input logic [AW-1:0] addr, input logic [TW-1:0] tag,
                           input logic [DW-1:0] data, input logic [BE-1:0] be,
                           input int sb, input int sn, input int eb, input int rd);
        start_txn(rw, addr, tag, data, be, sb, sn, eb, rd);
        for (int i = 0; i < 600 && !done; i++) cycle();
        chk("txn_done", done, 1);
        b.mem_req_valid = 1'b0;
    endtask

    // expectations from the line-level rules: address walk, strobes, reference memory contents
    task automatic check_txn(input bit rw, input logic [TW-1:0] tag, input logic [DW-1:0] data,
                             input logic [BE-1:0] be, input int eb, input int rd);
        int mism;
        logic [DW-1:0] exp_line;
        logic [31:0] wd;
        chk("addr_count", a_log.size(), BEATS);
        mism = 0;
        for (int i = 0; i < BEATS && i < a_log.size(); i++)
            if (a_log[i] !== line_base + 32'(4 * i) ||
                t_log[i] !== ((i == 0 || i == eb + 1) ? 2'b10 : 2'b11)) mism++;
        chk("addr_seq", mism, 0);
        if (rw) begin
            mism = 0;
            for (int i = 0; i < BEATS; i++) begin
                if (i >= s_log.size() || s_log[i] !== be[i*4 +: 4]) mism++;
                wd = rrd(line_base + 32'(4 * i));
                for (int k = 0; k < 4; k++) if (be[i*4 + k]) wd[k*8 +: 8] = data[(i*4 + k)*8 +: 8];
                rmem[line_base + 32'(4 * i)] = wd;
            end
            chk("wr_strobes", mism, 0);
            chk("wr_no_rsp", rsp_cnt, 0);
        end else begin
            for (int i = 0; i < BEATS; i++)
                exp_line[i*32 +: 32] = (i == eb) ? 32'h0 : rrd(line_base + 32'(4 * i));
            chk("rd_data", rsp_data, exp_line);
            chk("rd_tag", rsp_tag, tag);
            chk("rsp_cycles", rsp_cnt, rd + 1);
        end
        if (eb >= 0) exp_errs = exp_errs < 255 ? exp_errs + 1 : 255;
        chk("err_pulses", err_pulses, eb >= 0 ? 1 : 0);
        chk("err_count", err_count, exp_errs);
        chk("rsp_hold", hold_bad, 0);
        chk("protocol", proto_bad, 0);
        chk("stall_stable", stab_bad, 0);
    endtask

    typedef struct {
        bit            rw;
        logic [AW-1:0] addr;
        logic [TW-1:0] tag;
        logic [BE-1:0] be;
        int            sb, sn, eb, rd;
        int            lat;
    } vec_t;

    initial begin
        vec_t vt[5];
        logic [DW-1:0] data;
        logic [BE-1:0] be;
        bit rw;
        vt[0] = '{0, 26'h10, 8'h5A, 64'h0,    -1, 0, -1, 0, 18};
        vt[1] = '{1, 26'h01, 8'h11, 64'h000F, -1, 0, -1, 0, 18};
        vt[2] = '{0, 26'h10, 8'h22, 64'h0,     3, 2, -1, 0, 20};
        vt[3] = '{0, 26'h10, 8'h33, 64'h0,    -1, 0,  5, 0, 19};
        vt[4] = '{0, 26'h01, 8'h44, 64'h0,    -1, 0, -1, 5, 18};
        for (int k = 0; k < BEATS; k++) begin
            smem[32'h400 + 32'(4 * k)] = 32'(k);
            rmem[32'h400 + 32'(4 * k)] = 32'(k);
        end
        reset = 1'b1;
        b.mem_req_valid = 0; b.mem_req_rw = 0; b.mem_req_byteen = '0; b.mem_req_addr = '0;
        b.mem_req_data = '0; b.mem_req_tag = '0; b.mem_rsp_ready = 0;
        b.HREADY = 1; b.HRESP = 0; b.HRDATA = '0;
        w.mem_req_valid = 0; w.mem_req_rw = 0; w.mem_req_byteen = '0; w.mem_req_addr = '0;
        w.mem_req_data = '0; w.mem_req_tag = '0; w.mem_rsp_ready = 1;
        w.HREADY = 1; w.HRESP = 0; w.HRDATA = '0;
        stall_pct = 0; stall_beat = -1; err_beat = -1; exp_errs = 0; dp_v = 0; p_ok = 0; cyc = 0;
        #12;
        chk("reset_ctrl", {b.mem_req_ready, b.HSIZE, b.HBURST, b.HTRANS, b.HSEL, b.HWRITE,
                           busy, b.mem_rsp_valid, bus_err, err_count},
                          {1'b1, 3'd2, 3'd1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0});
        chk("reset_bus", {b.HADDR, b.HWDATA, b.HWSTRB, b.mem_rsp_tag}, '0);
        @(posedge clk); #1;
        reset = 1'b0;

        for (int v = 0; v < 5; v++) begin
            for (int i = 0; i < BEATS; i++) data[i*32 +: 32] = $urandom();
            run_txn(vt[v].rw, vt[v].addr, vt[v].tag, data, vt[v].be, vt[v].sb, vt[v].sn, vt[v].eb, vt[v].rd);
            chk("latency", t_done - t_acc, vt[v].lat);
            check_txn(vt[v].rw, vt[v].tag, data, vt[v].be, vt[v].eb, vt[v].rd);
        end

        stall_pct = 25;
        for (int n = 0; n < 25; n++) begin
            rw = 1'($urandom_range(1));
            for (int i = 0; i < BEATS; i++) data[i*32 +: 32] = $urandom();
            be = {$urandom(), $urandom()};
            run_txn(rw, 26'h20 + 26'($urandom_range(3)), 8'($urandom()), data, be, -1, 0, -1,
                    $urandom_range(3));
            check_txn(rw, b.mem_req_tag, data, be, -1, rsp_delay);
        end
        stall_pct = 0;

        start_txn(0, 26'h10, 8'h66, '0, '0, -1, 0, -1, 0);
        for (int i = 0; i < 100 && a_log.size() < 7; i++) cycle();
        chk("pre_reset_busy", {busy, b.HTRANS}, {1'b1, 2'b11});
        #2 reset = 1'b1;
        #1;
        chk("midrst_ctrl", {b.mem_req_ready, b.HSIZE, b.HBURST, b.HTRANS, b.HSEL, busy,
                            b.mem_rsp_valid, err_count},
                           {1'b1, 3'd2, 3'd1, 2'b00, 1'b0, 1'b0, 1'b0, 8'd0});
        chk("midrst_addr", b.HADDR, 0);
        @(posedge clk); #1;
        reset = 1'b0; dp_v = 0; p_ok = 0; exp_errs = 0;
        b.HREADY = 1; b.HRESP = 0; b.mem_req_valid = 0;
        run_txn(0, 26'h10, 8'h77, '0, '0, -1, 0, -1, 0);
        chk("post_rst_latency", t_done - t_acc, 18);
        check_txn(0, 8'h77, '0, '0, -1, 0);

        w.mem_req_addr = 26'h1; w.mem_req_valid = 1'b1;
        @(negedge clk);
        chk("wrap_accept", w.mem_req_ready, 1);
        @(posedge clk); #1;
        w.mem_req_valid = 1'b0;
        @(negedge clk);
        chk("wrap_beat0", {w.HADDR, w.HTRANS}, {32'h0, 2'b10});
        @(negedge clk);
        chk("wrap_beat1", {w.HADDR, w.HTRANS}, {32'h4, 2'b11});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/vx_ahb_line_bridge.md
Name: vx_ahb_line_bridge

Overview:
- Parametrised successor to the single-beat Vortex-to-AHB adapter.
- Converts one Vortex memory-line request (DATA_W bits) into a pipelined AHB-Lite INCR burst of BEATS = DATA_W/HDATA_W beats.
- Reassembles read beats into a line response carrying the original tag. Reports bus errors.
- Sits between the Vortex top-level memory port and the AHB subordinate/memory slave.

Parameters:
- DATA_W, 512, Vortex line width in bits; must be a multiple of HDATA_W.
- HDATA_W, 32, AHB data width in bits; 32 or 64.
- ADDR_W, 26, Vortex line address width.
- TAG_W, 8, Vortex request tag width.
- HADDR_W, 32, AHB address width.
- BASE_ADDR, 32'h0, byte offset added to every generated HADDR.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- mem_req_valid  in  1  request valid
- mem_req_rw  in  1  1 = write, 0 = read
- mem_req_byteen  in  DATA_W/8  byte enables
- mem_req_addr  in  ADDR_W  line address
- mem_req_data  in  DATA_W  write line data
- mem_req_tag  in  TAG_W  request tag
- mem_req_ready  out  1  bridge can accept a request
- mem_rsp_valid  out  1  read response valid
- mem_rsp_data  out  DATA_W  read line data
- mem_rsp_tag  out  TAG_W  tag of the returned line
- mem_rsp_ready  in  1  consumer accepts the response
- HSEL  out  1  AHB select
- HWRITE  out  1  AHB write
- HTRANS  out  2  AHB transfer type
- HBURST  out  3  AHB burst type
- HSIZE  out  3  AHB transfer size
- HADDR  out  HADDR_W  AHB address
- HWDATA  out  HDATA_W  AHB write data
- HWSTRB  out  HDATA_W/8  AHB write strobes
- HREADY  in  1  AHB ready
- HRESP  in  1  AHB error response
- HRDATA  in  HDATA_W  AHB read data
- busy  out  1  bridge not idle
- bus_err  out  1  one-cycle pulse per errored beat
- err_count  out  8  saturating count of errored beats

Behaviour:
- Reset (asynchronous, active-high): state IDLE.
  - All outputs 0, except mem_req_ready=1, HSIZE=log2(HDATA_W/8), HBURST=3'b001.
  - Line buffer and tag register cleared; any in-flight AHB transfer is abandoned.
- States: IDLE, BURST, DRAIN, RSP.
- IDLE:
  - mem_req_ready=1.
  - On mem_req_valid && mem_req_ready: capture rw, byteen, addr, data and tag; set beat counters to 0; go to BURST.
- BURST (pipelined address and data phases):
  - Beat i address: BASE_ADDR + mem_req_addr*(DATA_W/8) + i*(HDATA_W/8), modulo 2^HADDR_W.
  - HTRANS: NONSEQ (2'b10) for beat 0, SEQ (2'b11) for later beats. HSEL=1 whenever HTRANS != IDLE.
  - The address counter advances only when HREADY=1.
  - When the last address is accepted: HTRANS=IDLE (2'b00), go to DRAIN.
- Data phase of beat i:
  - HWDATA = line[i*HDATA_W +: HDATA_W]; HWSTRB = byteen slice for beat i.
  - A zero strobe is still issued; beats are never skipped.
  - Reads capture HRDATA into line slot i on the cycle HREADY=1.
- DRAIN: waits for the final data phase (HREADY=1). Read → RSP; write → IDLE. Writes never produce a response.
- RSP:
  - mem_rsp_valid=1; data and tag held stable until mem_rsp_ready=1, then IDLE.
  - mem_req_ready=0 throughout RSP.
- Latency: zero-wait slave, read accepted at cycle T:
  - Address phases T+1..T+BEATS; data phases T+2..T+BEATS+1.
  - mem_rsp_valid at T+BEATS+2.
  - Write returns to IDLE (ready=1) at T+BEATS+2.
- Wait states: HREADY=0 freezes HADDR, HTRANS, HWDATA, HWSTRB and both counters.
- Error response (HRESP=1 with HREADY=0, then HRESP=1 with HREADY=1):
  - The first error cycle forces HTRANS=IDLE for that cycle.
  - The pending address beat is then re-issued as NONSEQ.
  - The errored beat completes on the second cycle; read slot is filled with 0.
  - bus_err pulses once; err_count increments, saturating at 255.
  - The burst always runs to completion.
- busy = (state != IDLE).
- Simultaneous events:
  - mem_rsp_ready in the RSP entry cycle is honoured.
  - A new request is not accepted in the same cycle the response is consumed.

Test Plan:
- Read, DATA_W=512/HDATA_W=32, addr=0x10, tag=0x5A, zero-wait slave preloaded word k=k → 16 beats at HADDR 0x400..0x43C; first NONSEQ, then SEQ; mem_rsp_valid at T+18; data words 0..15; tag 0x5A.
- Write, addr=0x1, byteen=16'h000F in beat 0 only, all other beats zero → 16 beats issued; beat 0 HWSTRB=4'hF, rest 4'h0; no mem_rsp_valid; ready=1 at T+18.
- Slave holds HREADY=0 for 2 cycles on beat 3 → all AHB outputs stable across the stall; read response at T+20 with correct data.
- Slave errors beat 5 → one idle cycle, then beat-6 address re-issued as NONSEQ; bus_err single pulse; err_count=1; rsp word 5 = 0, other words correct.
- mem_rsp_ready low 5 cycles → rsp_valid, data and tag held; mem_req_ready=0 until acceptance.
- Reset asserted mid-burst at beat 7 → outputs return to reset values immediately; next read completes normally. BASE_ADDR=32'hFFFFFFC0 with addr=1 wraps HADDR to 0x0.
